timer_display_decoder: RTL

Receive-side companion to the digital timer: accepts the six active-low 7-segment digit codes the timer drives and converts them back into BCD digits and a binary elapsed-seconds count. It sits between the timer display bus and any logic that needs numeric time, such as a logger, comparator or alarm. Conversion is multi-cycle, with one digit per cycle via a shift-add Horner chain, and the result is delivered over a valid/ready handshake.

---
 rtl/timer_display_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/timer_display_decoder.sv
// rtl/timer_display_decoder.sv - converts six active-low 7-segment timer digits back to BCD and elapsed seconds
// Optional feature macro: TIMER_DECODER_AUTO_TRIGGER_EN (re-trigger in IDLE whenever seg_in differs from the last snapshot)

module timer_display_decoder (
  input  logic            sys_clk,
  input  logic            int_reset_b,
  input  logic [5:0][6:0] seg_in,
  input  logic            start,
  input  logic            out_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [18:0]     total_sec,
  output logic [5:0][3:0] bcd_out,
  output logic            err
);

  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][6:0] snap_q, snap_d;
  logic [18:0]     acc_q, acc_d;
  logic [18:0]     total_q, total_d;
  logic [5:0][3:0] bcd_q, bcd_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  logic            trigger;
  logic [6:0]      cur_code;
  logic [3:0]      cur_digit;
  logic            cur_inv;
  logic [18:0]     sum;
  logic [18:0]     scaled;

  function automatic logic [4:0] seg_decode(input logic [6:0] code, input logic tens_pos);
    logic [3:0] d;
    logic       inv;
    inv = 1'b0;
    d   = 4'd0;
    case (code)
      7'b0000001: d = 4'd0;
      7'b1001111: d = 4'd1;
      7'b0010010: d = 4'd2;
      7'b0000110: d = 4'd3;
      7'b1001100: d = 4'd4;
      7'b0100100: d = 4'd5;
      7'b0100000: d = 4'd6;
      7'b0001111: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0000100: d = 4'd9;
      default:    inv = 1'b1;
    endcase
    if (tens_pos && d > 4'd5) inv = 1'b1;
    if (inv) d = 4'd0;
    return {inv, d};
  endfunction

`ifdef TIMER_DECODER_AUTO_TRIGGER_EN
  logic [5:0][6:0] seg_q, seg_d;

  always_comb seg_d = seg_in;

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) seg_q <= {6{SEG_ZERO}};
    else              seg_q <= seg_d;
  end

  assign trigger = start || (seg_q != snap_q);
`else
  assign trigger = start;
`endif

  // Horner step: add the digit, then scale by the ratio to the next lower position.
  always_comb begin
    cur_code = SEG_ZERO;
    for (int i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) cur_code = snap_q[i];
    end
    {cur_inv, cur_digit} = seg_decode(cur_code, (idx_q == 3'd1) || (idx_q == 3'd3));
    sum = acc_q + {15'd0, cur_digit};
    case (idx_q)
      3'd5, 3'd3, 3'd1: scaled = (sum << 3) + (sum << 1);
      3'd4, 3'd2:       scaled = (sum << 2) + (sum << 1);
      default:          scaled = sum;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    total_d = total_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = DECODE;
          snap_d  = seg_in;
          acc_d   = 19'd0;
          err_d   = 1'b0;
          idx_d   = 3'd5;
          busy_d  = 1'b1;
        end
      end
      DECODE: begin
        // Index wraps from 0 to 7 after the last digit; that cycle publishes the result.
        if (idx_q == 3'd7) begin
          total_d = acc_q;
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else begin
          acc_d = scaled;
          err_d = err_q | cur_inv;
          idx_d = idx_q - 3'd1;
          for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) bcd_d[i] = cur_digit;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      snap_q  <= {6{SEG_ZERO}};
      acc_q   <= 19'd0;
      total_q <= 19'd0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      total_q <= total_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign total_sec = total_q;
  assign bcd_out   = bcd_q;
  assign err       = err_q;

endmodule
